hazard_stall_unit: RTL

//  Consumer-side partner of the ID-stage forwarding logic. It handles the hazards

---
 rtl/hazard_stall_unit_pkg.sv | 7 +
 rtl/hazard_compare.sv | 13 +
 rtl/hazard_stall_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared cpu pipeline definitions (register width, NOP, stall FSM states)
package hazard_stall_unit_pkg;
    localparam int REG_W = 5;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
    typedef enum logic {RUN, MEM_WAIT} stallState_t;
endpackage

// File: rtl/hazard_compare.sv
// hazard_compare: load-use match of one ID source register against the load in EX
module hazard_compare
    import hazard_stall_unit_pkg::*;
(
    input  logic [REG_W-1:0] srcReg,
    input  logic             srcUsed,
    input  logic [REG_W-1:0] exDest,
    input  logic             exLoad,
    output logic             match
);
    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign match = exLoad & srcUsed & (|exDest) & (srcReg == exDest);
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/bubble/flush control for load-use, slow memory and taken branches,
// with a saturating count of PC-stall cycles.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_rA,
    input  logic [REG_W-1:0] ID_rB,
    input  logic             ID_useA,
    input  logic             ID_useB,
    input  logic [REG_W-1:0] ID_EX_rD,
    input  logic             ID_EX_memRd,
    input  logic             ID_EX_wrEn,
    input  logic             EX_MEM_memReq,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_stall,
    output logic             MEM_WB_bubble,
    output logic             IF_ID_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    stallState_t state, stateNext;
    logic [WAIT_W-1:0] waitCnt, waitNext;
    logic luA, luB, lu, memw, freeze, timeoutHit;

    hazard_compare cmpA (.srcReg(ID_rA), .srcUsed(ID_useA), .exDest(ID_EX_rD),
                         .exLoad(ID_EX_memRd & ID_EX_wrEn), .match(luA));
    hazard_compare cmpB (.srcReg(ID_rB), .srcUsed(ID_useB), .exDest(ID_EX_rD),
                         .exLoad(ID_EX_memRd & ID_EX_wrEn), .match(luB));

    assign lu   = luA | luB;
    assign memw = EX_MEM_memReq & ~mem_ready;

    // A withdrawn request in MEM_WAIT falls into the release branch with no timeout pulse
    always_comb begin
        stateNext  = state;
        waitNext   = waitCnt;
        freeze     = 1'b0;
        timeoutHit = 1'b0;
        if (state == RUN) begin
            if (memw) begin
                freeze    = 1'b1;
                stateNext = MEM_WAIT;
                waitNext  = WAIT_W'(1);
            end
        end else if (memw) begin
            freeze = 1'b1;
            if (waitCnt == WAIT_LAST) begin
                timeoutHit = 1'b1;
                stateNext  = RUN;
                waitNext   = '0;
            end else begin
                waitNext = waitCnt + 1'b1;
            end
        end else begin
            stateNext = RUN;
            waitNext  = '0;
        end
    end

    // Gating with reset drops every control the moment reset asserts
    assign PC_stall      = reset & (freeze | lu);
    assign IF_ID_stall   = reset & (freeze | lu);
    assign ID_EX_bubble  = reset & ~freeze & lu;
    assign EX_MEM_stall  = reset & freeze;
    assign MEM_WB_bubble = reset & freeze;
    assign IF_ID_flush   = reset & ~freeze & ~lu & branch_taken;
    assign mem_timeout   = reset & timeoutHit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            waitCnt      <= '0;
            stall_cycles <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
            if (PC_stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule
